bus_txn_scheduler: RTL and testbench
====================================

Name: bus_txn_scheduler

Overview:
- Shares the single 8-bit data bus between the AES and SHA FSMs at transaction granularity.
- Once a requester is granted, it owns the bus until it sends a beat marked last.
- Ownership rotates round-robin between the two requesters.
- Includes a one-entry registered output stage that honours bus_ready backpressure, and a stall watchdog that reclaims the bus from a requester that goes silent mid-transaction.

Parameters:
TIMEOUT, 16, consecutive granted cycles with req low before the transaction is aborted (>=1)
CNTW, $clog2(TIMEOUT+1), watchdog counter width (derived; do not override)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
aes_req  input  1  AES has a valid beat on aes_data
aes_data  input  8  AES beat
aes_last  input  1  final beat of AES transaction
aes_grant  output  1  AES owns bus (registered)
aes_ready  output  1  AES beat accepted this cycle when aes_req=1 (combinational)
sha_req  input  1  SHA has a valid beat
sha_data  input  8  SHA beat
sha_last  input  1  final beat of SHA transaction
sha_grant  output  1  SHA owns bus (registered)
sha_ready  output  1  SHA beat accepted this cycle when sha_req=1 (combinational)
bus_ready  input  1  downstream consumes data_bus_out this cycle when data_bus_valid=1
data_bus_out  output  8  bus byte (registered)
data_bus_valid  output  1  bus byte valid (registered)
data_bus_last  output  1  bus byte ends a transaction (registered)
owner  output  1  0=AES, 1=SHA; source of the current or most recent beat
err_timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
Reset (rst_n=0 at a clk edge):
- All outputs go to 0.
- State=IDLE, last_served=SHA (so AES wins the first tie), watchdog=0.
- Reset mid-transaction drops any held output byte without emitting it.

States:
- IDLE:
  - aes_grant=sha_grant=0; both ready outputs = 0.
  - Arbitration is evaluated every cycle.
  - Only one req high: that requester goes to XFER next cycle.
  - Both high: the requester != last_served goes to XFER.
  - Neither high: stay in IDLE.
  - The grant register asserts on entry to XFER. A transaction boundary therefore always costs exactly one IDLE cycle.
- XFER_AES / XFER_SHA (x = the owning requester):
  - grant_x=1; the other grant and ready are 0.
  - slot_free = !data_bus_valid | bus_ready.
  - ready_x = grant_x & slot_free.
  - Beat accepted when req_x & ready_x: next cycle data_bus_out=data_x, data_bus_valid=1, data_bus_last=last_x, owner=x.
  - Accepted beat with last_x=1: next state IDLE, last_served<=x, grant_x drops the following cycle.
  - The non-granted requester's req, data and last are ignored entirely.

Output stage:
- When data_bus_valid & bus_ready and no beat is accepted that cycle, data_bus_valid<=0 and data_bus_last<=0.
- When data_bus_valid=1 and bus_ready=0, data_bus_out, data_bus_valid and data_bus_last hold stable.
- Throughput is 1 beat/cycle while bus_ready=1 and req_x=1.
- Latency is 1 cycle from acceptance to data_bus_valid.
- The output byte may still be pending in IDLE. The next transaction's first beat cannot be accepted until slot_free.

Watchdog (XFER only):
- Counter increments each cycle req_x=0.
- Counter clears on any cycle req_x=1, and on state entry.
- Backpressure stalls (req_x=1, ready_x=0) do not count.
- When the counter reaches TIMEOUT:
  - err_timeout pulses 1 for one cycle;
  - next state is IDLE and last_served<=x;
  - no last marker is fabricated;
  - the pending output byte, if any, still drains normally.
- Abort and last-beat acceptance cannot coincide, because abort requires req_x=0.

Widths:
- Watchdog saturates at TIMEOUT and cannot wrap, since it clears on the abort transition.

Test Plan:
1. Single transaction: after reset, aes_req=1 with bytes 0xA0,0xA1,0xA2 (last on 0xA2), bus_ready=1 -> aes_grant=1 at cycle 1; data_bus_out 0xA0,0xA1,0xA2 on cycles 2-4 with last only on 0xA2; aes_grant=0 at cycle 4; owner=0.
2. Simultaneous requests: both req from reset, 2-beat transactions each -> AES served first, then one IDLE cycle, then SHA; repeating both -> AES, SHA, AES order.
3. Backpressure: during a 4-beat SHA transaction, hold bus_ready=0 for 5 cycles at beat 2 -> data_bus_out holds beat 2 stable, sha_ready=0, no watchdog pulse, no beat lost or duplicated.
4. Watchdog: with TIMEOUT=16, SHA sends 1 non-last beat then drops sha_req -> err_timeout pulses exactly 16 cycles after req drops; sha_grant deasserts; a pending AES request is granted after one IDLE cycle.
5. Non-owner isolation: during an AES transaction, toggle sha_req/sha_data/sha_last -> no SHA byte appears on the bus and sha_ready stays 0 throughout.
6. Reset mid-transfer: assert rst_n=0 with data_bus_valid=1, bus_ready=0 -> all outputs 0 next cycle; after release, AES wins the first tie.

Source files
------------

// File: rtl/bus_txn_scheduler.sv
// Transaction-granular round-robin sharing of one 8-bit bus between AES and SHA,
// with a one-entry registered output stage and a stall watchdog.
module bus_txn_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       aes_req,
  input  logic [7:0] aes_data,
  input  logic       aes_last,
  output logic       aes_grant,
  output logic       aes_ready,
  input  logic       sha_req,
  input  logic [7:0] sha_data,
  input  logic       sha_last,
  output logic       sha_grant,
  output logic       sha_ready,
  input  logic       bus_ready,
  output logic [7:0] data_bus_out,
  output logic       data_bus_valid,
  output logic       data_bus_last,
  output logic       owner,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_AES = 2'd1,
    XFER_SHA = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] WD_MAX = CNTW'(TIMEOUT);

  state_t          state, state_nx;
  logic            last_served, last_served_nx;
  logic [CNTW-1:0] wd_cnt, wd_cnt_nx;

  logic       xfer;
  logic       owner_x;
  logic       req_x;
  logic       last_x;
  logic [7:0] data_x;
  logic       slot_free;
  logic       accept;
  logic       abort;

  always_comb begin
    xfer      = (state == XFER_AES) || (state == XFER_SHA);
    owner_x   = (state == XFER_SHA);
    req_x     = xfer && (owner_x ? sha_req : aes_req);
    last_x    = owner_x ? sha_last : aes_last;
    data_x    = owner_x ? sha_data : aes_data;
    slot_free = !data_bus_valid || bus_ready;
    accept    = req_x && slot_free;
    // Abort needs req low, so it can never collide with a last-beat accept.
    abort     = xfer && !req_x && (wd_cnt == WD_MAX);
  end

  assign aes_ready   = aes_grant && slot_free;
  assign sha_ready   = sha_grant && slot_free;
  assign err_timeout = abort;

  always_comb begin
    state_nx       = state;
    last_served_nx = last_served;
    wd_cnt_nx      = wd_cnt;
    case (state)
      XFER_AES, XFER_SHA: begin
        if ((accept && last_x) || abort) begin
          state_nx       = IDLE;
          last_served_nx = owner_x;
          wd_cnt_nx      = '0;
        end else if (req_x) begin
          wd_cnt_nx = '0;
        end else if (wd_cnt != WD_MAX) begin
          wd_cnt_nx = wd_cnt + CNTW'(1);
        end
      end
      default: begin
        wd_cnt_nx = '0;
        state_nx  = IDLE;
        if (aes_req && (!sha_req || last_served)) begin
          state_nx = XFER_AES;
        end else if (sha_req) begin
          state_nx = XFER_SHA;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_served    <= 1'b1;
      wd_cnt         <= '0;
      aes_grant      <= 1'b0;
      sha_grant      <= 1'b0;
      data_bus_out   <= '0;
      data_bus_valid <= 1'b0;
      data_bus_last  <= 1'b0;
      owner          <= 1'b0;
    end else begin
      state       <= state_nx;
      last_served <= last_served_nx;
      wd_cnt      <= wd_cnt_nx;
      aes_grant   <= (state_nx == XFER_AES);
      sha_grant   <= (state_nx == XFER_SHA);
      if (accept) begin
        data_bus_out   <= data_x;
        data_bus_valid <= 1'b1;
        data_bus_last  <= last_x;
        owner          <= owner_x;
      end else if (data_bus_valid && bus_ready) begin
        data_bus_valid <= 1'b0;
        data_bus_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_txn_scheduler.sv
// Bench for bus_txn_scheduler: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a transaction-level model.
module tb_bus_txn_scheduler;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       aes_req = 1'b0, aes_last = 1'b0, sha_req = 1'b0, sha_last = 1'b0;
  logic [7:0] aes_data = '0, sha_data = '0;
  logic       bus_ready = 1'b0;
  logic       aes_grant, aes_ready, sha_grant, sha_ready;
  logic [7:0] data_bus_out;
  logic       data_bus_valid, data_bus_last, owner, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_txn_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .aes_req(aes_req), .aes_data(aes_data), .aes_last(aes_last),
    .aes_grant(aes_grant), .aes_ready(aes_ready),
    .sha_req(sha_req), .sha_data(sha_data), .sha_last(sha_last),
    .sha_grant(sha_grant), .sha_ready(sha_ready),
    .bus_ready(bus_ready), .data_bus_out(data_bus_out),
    .data_bus_valid(data_bus_valid), .data_bus_last(data_bus_last),
    .owner(owner), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the bus (0 none, 1 AES, 2 SHA), who was served last,
  // how long the holder has been silent, and the single pending output byte.
  int         m_own = 0;
  int         m_last_served = 2;
  int         m_quiet = 0;
  bit         m_valid = 0, m_lastb = 0, m_init = 0;
  logic [7:0] m_data = '0;
  int         m_owner = 0;

  always @(negedge clk) begin
    bit         req_o, last_o, slot, acc, exp_err;
    logic [7:0] dat_o;
    req_o   = (m_own == 1) ? aes_req  : (m_own == 2) ? sha_req  : 1'b0;
    last_o  = (m_own == 1) ? aes_last : sha_last;
    dat_o   = (m_own == 1) ? aes_data : sha_data;
    slot    = !m_valid || bus_ready;
    acc     = req_o && slot;
    exp_err = (m_own != 0) && !req_o && (m_quiet >= TIMEOUT);
    if (m_init) begin
      chk("aes_grant", aes_grant, m_own == 1);
      chk("sha_grant", sha_grant, m_own == 2);
      chk("aes_ready", aes_ready, (m_own == 1) && slot);
      chk("sha_ready", sha_ready, (m_own == 2) && slot);
      chk("bus_valid", data_bus_valid, m_valid);
      chk("bus_data", data_bus_out, m_data);
      chk("bus_last", data_bus_last, m_lastb);
      chk("owner", owner, m_owner);
      chk("err_timeout", err_timeout, exp_err);
    end
    if (!rst_n) begin
      m_own = 0; m_last_served = 2; m_quiet = 0;
      m_valid = 0; m_lastb = 0; m_data = '0; m_owner = 0; m_init = 1;
    end else if (m_init) begin
      if (acc) begin
        m_valid = 1; m_data = dat_o; m_lastb = last_o; m_owner = m_own - 1;
      end else if (m_valid && bus_ready) begin
        m_valid = 0; m_lastb = 0;
      end
      if (m_own == 0) begin
        m_quiet = 0;
        if (aes_req && sha_req) m_own = (m_last_served == 1) ? 2 : 1;
        else if (aes_req)       m_own = 1;
        else if (sha_req)       m_own = 2;
      end else if ((acc && last_o) || exp_err) begin
        m_last_served = m_own; m_own = 0; m_quiet = 0;
      end else if (req_o) begin
        m_quiet = 0;
      end else if (m_quiet < TIMEOUT) begin
        m_quiet++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    aes_req = 0; sha_req = 0; aes_last = 0; sha_last = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 0;
    tick();
    chk("rst_valid", data_bus_valid, 0);
    chk("rst_grants", {aes_grant, sha_grant}, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1;
  endtask

  int pa, ps, pb;

  initial begin
    tick();
    // Single AES transaction
    do_reset();
    aes_req = 1; aes_data = 8'hA0; bus_ready = 1;
    tick(); chk("t1_grant_c1", aes_grant, 1);
    tick(); chk("t1_data_c2", data_bus_out, 8'hA0); chk("t1_last_c2", data_bus_last, 0);
    aes_data = 8'hA1;
    tick(); chk("t1_data_c3", data_bus_out, 8'hA1);
    aes_data = 8'hA2; aes_last = 1;
    tick(); chk("t1_data_c4", data_bus_out, 8'hA2); chk("t1_last_c4", data_bus_last, 1);
    chk("t1_grant_c4", aes_grant, 0); chk("t1_owner", owner, 0);
    quiet_inputs();
    repeat (3) tick();

    // Simultaneous requests: AES, IDLE, SHA, IDLE, AES
    do_reset();
    aes_req = 1; sha_req = 1; aes_data = 8'hC0; sha_data = 8'hD0; bus_ready = 1;
    tick(); chk("t2_aes_first", aes_grant, 1); chk("t2_sha_wait", sha_grant, 0);
    tick(); chk("t2_c0", data_bus_out, 8'hC0);
    aes_data = 8'hC1; aes_last = 1;
    tick(); chk("t2_idle", {aes_grant, sha_grant}, 0); chk("t2_c1", data_bus_out, 8'hC1);
    chk("t2_c1_last", data_bus_last, 1);
    aes_last = 0; aes_data = 8'hC2;
    tick(); chk("t2_sha_grant", sha_grant, 1);
    tick(); chk("t2_d0", data_bus_out, 8'hD0); chk("t2_owner_sha", owner, 1);
    sha_data = 8'hD1; sha_last = 1;
    tick(); chk("t2_d1", data_bus_out, 8'hD1); chk("t2_idle2", {aes_grant, sha_grant}, 0);
    sha_last = 0;
    tick(); chk("t2_aes_again", aes_grant, 1);
    aes_last = 1;
    tick(); quiet_inputs();
    repeat (3) tick();

    // Backpressure on a SHA transaction
    do_reset();
    sha_req = 1; sha_data = 8'hE0; bus_ready = 1;
    tick(); chk("t3_grant", sha_grant, 1);
    tick(); chk("t3_e0", data_bus_out, 8'hE0);
    sha_data = 8'hE1;
    tick(); chk("t3_e1", data_bus_out, 8'hE1);
    bus_ready = 0; sha_data = 8'hE2; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", data_bus_out, 8'hE1);
      chk("t3_hold_ready", sha_ready, 0);
      chk("t3_no_err", err_timeout, 0);
      tick();
    end
    bus_ready = 1;
    tick(); chk("t3_e2", data_bus_out, 8'hE2);
    sha_data = 8'hE3; sha_last = 1;
    tick(); chk("t3_e3", data_bus_out, 8'hE3); chk("t3_e3_last", data_bus_last, 1);
    quiet_inputs();
    repeat (3) tick();

    // Watchdog abort, then pending AES granted after one IDLE cycle
    do_reset();
    sha_req = 1; sha_data = 8'h55; bus_ready = 1;
    tick(); chk("t4_grant", sha_grant, 1);
    tick(); sha_req = 0; aes_req = 1; aes_data = 8'h66;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("t4_no_err_early", err_timeout, 0);
      tick();
    end
    chk("t4_err_pulse", err_timeout, 1); chk("t4_still_sha", sha_grant, 1);
    tick(); chk("t4_err_done", err_timeout, 0); chk("t4_idle", {aes_grant, sha_grant}, 0);
    chk("t4_no_fake_last", data_bus_last, 0);
    tick(); chk("t4_aes_grant", aes_grant, 1);
    aes_last = 1;
    tick(); quiet_inputs();
    repeat (2) tick();

    // Non-owner isolation during AES transaction
    do_reset();
    aes_req = 1; aes_data = 8'h10; bus_ready = 1;
    for (int i = 0; i < 8; i++) begin
      sha_req = $urandom_range(0, 1); sha_data = 8'hF0 | 8'($urandom_range(0, 15));
      sha_last = $urandom_range(0, 1); aes_data = 8'h10 + 8'(i);
      #1;
      chk("t5_sha_ready", sha_ready, 0);
      if (data_bus_valid) chk("t5_owner", owner, 0);
      tick();
    end
    aes_last = 1; sha_req = 0;
    tick(); quiet_inputs();
    repeat (2) tick();

    // Reset while a byte is stuck behind backpressure
    do_reset();
    aes_req = 1; aes_data = 8'h11; bus_ready = 0;
    tick(); tick();
    chk("t6_pending", data_bus_valid, 1); chk("t6_pending_data", data_bus_out, 8'h11);
    rst_n = 0;
    tick();
    chk("t6_valid", data_bus_valid, 0); chk("t6_data", data_bus_out, 0);
    chk("t6_grant", aes_grant, 0); chk("t6_owner", owner, 0);
    rst_n = 1; aes_req = 1; sha_req = 1; bus_ready = 1;
    tick(); chk("t6_aes_tie", aes_grant, 1); chk("t6_sha_tie", sha_grant, 0);
    quiet_inputs();
    repeat (2) tick();

    // Randomized traffic
    pa = 50; ps = 50; pb = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        pa = $urandom_range(3, 100); ps = $urandom_range(3, 100); pb = $urandom_range(20, 100);
      end
      aes_req   = ($urandom_range(0, 99) < pa);
      sha_req   = ($urandom_range(0, 99) < ps);
      aes_data  = 8'($urandom);
      sha_data  = 8'($urandom);
      aes_last  = ($urandom_range(0, 3) == 0);
      sha_last  = ($urandom_range(0, 3) == 0);
      bus_ready = ($urandom_range(0, 99) < pb);
      rst_n     = ($urandom_range(0, 799) != 0);
      tick();
    end
    rst_n = 1; quiet_inputs();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
